frame_bram_writer: RTL and testbench
====================================

Name: frame_bram_writer

Overview:
- Downstream consumer of the periodic frame-reset pulse counter in the BRAM test path of the DTC tester.
- Shift register that packs LANES narrow input words into one wide word per frame, with frame boundaries taken from the counter's single-cycle pulse.
- Commits each complete frame to a simple-dual-port BRAM write port, advancing the write address.
- Counts good and malformed frames for readout via VIO/ILA.

Parameters:
- DIN_W, 8, width of each input word
- LANES, 4, words per frame; BRAM data width = LANES*DIN_W
- ADDR_W, 10, BRAM address width; depth = 2**ADDR_W
- CNT_W, 16, width of frame statistics counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- arm  in  1  level or pulse (VIO); starts a capture run
- frame_pulse  in  1  single-cycle frame boundary from the counter
- din_valid  in  1  din qualifier
- din  in  DIN_W  input word
- bram_we  out  1  BRAM write enable, one cycle per committed frame
- bram_addr  out  ADDR_W  BRAM write address
- bram_wdata  out  LANES*DIN_W  packed frame
- busy  out  1  high in SYNC or FILL
- done  out  1  high when BRAM is full; run complete
- frames_ok  out  CNT_W  frames committed, saturating
- frames_bad  out  CNT_W  frames discarded (short or long), saturating

Behaviour:
- Reset is synchronous, active-high; clock clk. On reset:
  - bram_we=0, bram_addr=0, bram_wdata=0
  - busy=0, done=0, frames_ok=0, frames_bad=0
  - shift register and word count cleared; state IDLE
- Reset mid-frame discards the partial frame with no write.
- State IDLE:
  - All inputs except arm ignored.
  - arm=1 -> SYNC: clear bram_addr, frames_ok, frames_bad, word count.
- State SYNC:
  - din discarded.
  - frame_pulse -> FILL; the pulse cycle opens the first frame.
- State FILL:
  - Each din_valid cycle shifts din into the top lane; the register shifts down one lane.
  - After k words, the first word sits in lane LANES-k; after LANES words the first word is in bits [DIN_W-1:0].
  - Word count saturates at LANES+1.
  - A din_valid on a frame_pulse cycle is the first word of the new frame, never the last of the closing one.
- On frame_pulse in FILL (frame close):
  - count==LANES: next cycle bram_we=1, bram_wdata=packed register, bram_addr=current address; address increments after the write; frames_ok+1.
  - count<LANES (short) or count>LANES (long): no write; frames_bad+1.
  - Either way, count restarts at 0, or at 1 if din_valid is on the pulse cycle.
  - Frame-close latency: exactly 1 cycle from frame_pulse to bram_we.
- Full buffer:
  - A write to address 2**ADDR_W-1 moves the block to DONE on the same edge the write is issued. No wrap.
- State DONE:
  - done=1, busy=0, no writes; frame_pulse and din ignored.
  - arm=1 -> SYNC (re-arm clears address and counters).
- arm in SYNC or FILL: ignored.
- Counters saturate at all-ones.
- Output register rules:
  - bram_we is a registered single-cycle pulse.
  - bram_wdata and bram_addr hold their last values when bram_we=0.

Decomposition:
- Package frame_bram_pkg:
  - state enum: IDLE, SYNC, FILL, DONE
  - localparam FRAME_W = LANES*DIN_W
  - localparam DEPTH = 2**ADDR_W
- One sub-module, lane_shift_reg (DIN_W, LANES): shift-in register with saturating word count and a clear/preload-on-boundary input.
- The FSM, address counter and statistics stay in the top module.

Test Plan:
(all with DIN_W=8, LANES=4, ADDR_W=4)
- Nominal frame: rst, arm, frame_pulse, then din 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then frame_pulse -> next cycle bram_we=1, bram_addr=0, bram_wdata=0x44332211, frames_ok=1; following write uses addr=1.
- Short frame: 3 words (0xAA,0xBB,0xCC) then pulse -> no bram_we, frames_bad=1, address unchanged. Long frame: 5 words then pulse -> no write, frames_bad=2.
- Boundary coincidence: din_valid with 0x55 on the frame_pulse cycle, then 0x66,0x77,0x88, then pulse -> bram_wdata=0x88776655.
- Pre-sync data: arm, then 4 words before the first frame_pulse -> no write, frames_bad=0, busy=1.
- Full buffer: 16 good frames -> last write at addr=15, done=1 on the same edge; a 17th frame produces no bram_we; arm then restarts with addr=0, frames_ok=0.
- Reset mid-frame: rst after 2 words -> all outputs zero, state IDLE; a subsequent frame_pulse without arm produces no write.

Source files
------------

// File: rtl/frame_bram_pkg.sv
// Shared constants for the BRAM frame writer: default geometry and FSM state encodings.
package frame_bram_pkg;

    localparam int DEF_DIN_W  = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CNT_W  = 16;

    localparam int FRAME_W = DEF_LANES * DEF_DIN_W;
    localparam int DEPTH   = 2 ** DEF_ADDR_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SYNC = 2'd1;
    localparam state_t ST_FILL = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/lane_shift_reg.sv
// Packs narrow words into a wide frame register; the oldest word ends up in the lowest lane.
module lane_shift_reg #(
    parameter int DIN_W = 8,
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         boundary,
    input  logic                         shift_en,
    input  logic [DIN_W-1:0]             din,
    output logic [LANES*DIN_W-1:0]       data,
    output logic [$clog2(LANES+2)-1:0]   count
);

    localparam int DATA_W   = LANES * DIN_W;
    localparam int CNT_BITS = $clog2(LANES + 2);

    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    // A boundary restarts the frame; a word arriving on it becomes the new frame's first word.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (clear) begin
            data_d  = '0;
            count_d = '0;
        end else if (boundary) begin
            data_d  = shift_en ? {din, {(DATA_W-DIN_W){1'b0}}} : '0;
            count_d = shift_en ? CNT_BITS'(1) : '0;
        end else if (shift_en) begin
            data_d = {din, data_q[DATA_W-1:DIN_W]};
            if (count_q != CNT_BITS'(LANES + 1)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/frame_bram_writer.sv
// Captures pulse-delimited frames into a simple-dual-port BRAM write port and keeps good/bad frame statistics.
module frame_bram_writer
    import frame_bram_pkg::*;
#(
    parameter int DIN_W  = DEF_DIN_W,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    frame_pulse,
    input  logic                    din_valid,
    input  logic [DIN_W-1:0]        din,
    output logic                    bram_we,
    output logic [ADDR_W-1:0]       bram_addr,
    output logic [LANES*DIN_W-1:0]  bram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        frames_ok,
    output logic [CNT_W-1:0]        frames_bad
);

    localparam int DATA_W   = LANES * DIN_W;
    localparam int CNT_BITS = $clog2(LANES + 2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                bram_we_q, bram_we_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
    logic [CNT_W-1:0]    frames_ok_q, frames_ok_d;
    logic [CNT_W-1:0]    frames_bad_q, frames_bad_d;

    logic                lane_clear, lane_boundary, lane_shift;
    logic [DATA_W-1:0]   lane_data;
    logic [CNT_BITS-1:0] lane_count;

    lane_shift_reg #(
        .DIN_W (DIN_W),
        .LANES (LANES)
    ) u_lanes (
        .clk      (clk),
        .rst      (rst),
        .clear    (lane_clear),
        .boundary (lane_boundary),
        .shift_en (lane_shift),
        .din      (din),
        .data     (lane_data),
        .count    (lane_count)
    );

    // wr_addr_q is the next free slot; bram_addr_q holds the address of the last issued write.
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_wdata_d  = bram_wdata_q;
        frames_ok_d   = frames_ok_q;
        frames_bad_d  = frames_bad_q;
        lane_clear    = 1'b0;
        lane_boundary = 1'b0;
        lane_shift    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d      = ST_SYNC;
                    wr_addr_d    = '0;
                    bram_addr_d  = '0;
                    frames_ok_d  = '0;
                    frames_bad_d = '0;
                    lane_clear   = 1'b1;
                end
            end
            ST_SYNC: begin
                if (frame_pulse) begin
                    state_d       = ST_FILL;
                    lane_boundary = 1'b1;
                    lane_shift    = din_valid;
                end
            end
            ST_FILL: begin
                lane_shift = din_valid;
                if (frame_pulse) begin
                    lane_boundary = 1'b1;
                    if (lane_count == CNT_BITS'(LANES)) begin
                        bram_we_d    = 1'b1;
                        bram_wdata_d = lane_data;
                        bram_addr_d  = wr_addr_q;
                        wr_addr_d    = wr_addr_q + 1'b1;
                        frames_ok_d  = (&frames_ok_q) ? frames_ok_q : frames_ok_q + 1'b1;
                        if (&wr_addr_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        frames_bad_d = (&frames_bad_q) ? frames_bad_q : frames_bad_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign busy       = (state_q == ST_SYNC) || (state_q == ST_FILL);
    assign done       = (state_q == ST_DONE);
    assign frames_ok  = frames_ok_q;
    assign frames_bad = frames_bad_q;

endmodule

// File: tb/tb_frame_bram_writer.sv
// Directed bench for frame_bram_writer with a 16-entry BRAM: nominal, short/long, coincident, pre-sync, full-buffer and reset cases.
module tb_frame_bram_writer;

    localparam int DIN_W  = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   arm;
    logic                   frame_pulse;
    logic                   din_valid;
    logic [DIN_W-1:0]       din;
    logic                   bram_we;
    logic [ADDR_W-1:0]      bram_addr;
    logic [LANES*DIN_W-1:0] bram_wdata;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       frames_ok;
    logic [CNT_W-1:0]       frames_bad;

    int compared   = 0;
    int mismatched = 0;

    frame_bram_writer #(
        .DIN_W  (DIN_W),
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .frame_pulse (frame_pulse),
        .din_valid   (din_valid),
        .din         (din),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .busy        (busy),
        .done        (done),
        .frames_ok   (frames_ok),
        .frames_bad  (frames_bad)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so outputs are also sampled there.
    task automatic applyStimulus(input logic a, input logic p, input logic v, input logic [7:0] d);
        arm         = a;
        frame_pulse = p;
        din_valid   = v;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [7:0]  w;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("reset_we",    32'(bram_we),    32'd0);
        checkOutput("reset_addr",  32'(bram_addr),  32'd0);
        checkOutput("reset_wdata", bram_wdata,      32'd0);
        checkOutput("reset_busy",  32'(busy),       32'd0);
        checkOutput("reset_done",  32'(done),       32'd0);
        checkOutput("reset_ok",    32'(frames_ok),  32'd0);
        checkOutput("reset_bad",   32'(frames_bad), 32'd0);
        rst = 1'b0;

        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("arm_busy", 32'(busy), 32'd1);
        applyStimulus(0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h11);
        applyStimulus(0, 0, 1, 8'h22);
        applyStimulus(0, 0, 1, 8'h33);
        applyStimulus(0, 0, 1, 8'h44);
        checkOutput("nom_no_early_we", 32'(bram_we), 32'd0);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("nom_we",    32'(bram_we),   32'd1);
        checkOutput("nom_addr",  32'(bram_addr), 32'd0);
        checkOutput("nom_wdata", bram_wdata,     32'h44332211);
        checkOutput("nom_ok",    32'(frames_ok), 32'd1);

        applyStimulus(0, 0, 1, 8'h01);
        checkOutput("we_pulse_single", 32'(bram_we), 32'd0);
        checkOutput("wdata_hold",      bram_wdata,   32'h44332211);
        applyStimulus(0, 0, 1, 8'h02);
        applyStimulus(0, 0, 1, 8'h03);
        applyStimulus(0, 0, 1, 8'h04);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("nom2_we",    32'(bram_we),   32'd1);
        checkOutput("nom2_addr",  32'(bram_addr), 32'd1);
        checkOutput("nom2_wdata", bram_wdata,     32'h04030201);
        checkOutput("nom2_ok",    32'(frames_ok), 32'd2);

        applyStimulus(0, 0, 1, 8'hAA);
        applyStimulus(0, 0, 1, 8'hBB);
        applyStimulus(0, 0, 1, 8'hCC);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("short_we",   32'(bram_we),    32'd0);
        checkOutput("short_bad",  32'(frames_bad), 32'd1);
        checkOutput("short_addr", 32'(bram_addr),  32'd1);
        checkOutput("short_ok",   32'(frames_ok),  32'd2);

        for (int k = 0; k < 5; k++) begin
            w = 8'(8'hD1 + k);
            applyStimulus(0, 0, 1, w);
        end
        applyStimulus(0, 1, 1, 8'h55);
        checkOutput("long_we",  32'(bram_we),    32'd0);
        checkOutput("long_bad", 32'(frames_bad), 32'd2);

        applyStimulus(0, 0, 1, 8'h66);
        applyStimulus(0, 0, 1, 8'h77);
        applyStimulus(0, 0, 1, 8'h88);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("coin_we",    32'(bram_we),   32'd1);
        checkOutput("coin_wdata", bram_wdata,     32'h88776655);
        checkOutput("coin_addr",  32'(bram_addr), 32'd2);
        checkOutput("coin_ok",    32'(frames_ok), 32'd3);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            w = 8'(8'hC0 + k);
            applyStimulus(0, 0, 1, w);
            checkOutput("presync_we", 32'(bram_we), 32'd0);
        end
        checkOutput("presync_bad",  32'(frames_bad), 32'd0);
        checkOutput("presync_ok",   32'(frames_ok),  32'd0);
        checkOutput("presync_busy", 32'(busy),       32'd1);

        applyStimulus(0, 1, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_word = 32'd0;
            for (int k = 0; k < 4; k++) begin
                w = 8'(i * 16 + k);
                exp_word = {w, exp_word[31:8]};
                applyStimulus(0, 0, 1, w);
            end
            applyStimulus(0, 1, 0, 8'h00);
            checkOutput("full_we",    32'(bram_we),   32'd1);
            checkOutput("full_addr",  32'(bram_addr), 32'(i));
            checkOutput("full_wdata", bram_wdata,     exp_word);
            checkOutput("full_done",  32'(done),      (i == 15) ? 32'd1 : 32'd0);
        end
        checkOutput("full_ok",   32'(frames_ok), 32'd16);
        checkOutput("full_busy", 32'(busy),      32'd0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 8'hEE);
        end
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("over_we",   32'(bram_we),   32'd0);
        checkOutput("over_addr", 32'(bram_addr), 32'd15);
        checkOutput("over_done", 32'(done),      32'd1);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("over_we2",  32'(bram_we),   32'd0);
        checkOutput("over_ok",   32'(frames_ok), 32'd16);

        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("rearm_addr", 32'(bram_addr), 32'd0);
        checkOutput("rearm_ok",   32'(frames_ok), 32'd0);
        checkOutput("rearm_done", 32'(done),      32'd0);
        checkOutput("rearm_busy", 32'(busy),      32'd1);
        applyStimulus(0, 1, 0, 8'h00);
        applyStimulus(0, 0, 1, 8'h10);
        applyStimulus(0, 0, 1, 8'h11);
        applyStimulus(0, 0, 1, 8'h12);
        applyStimulus(0, 0, 1, 8'h13);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("rearm_we",    32'(bram_we),   32'd1);
        checkOutput("rearm_waddr", 32'(bram_addr), 32'd0);
        checkOutput("rearm_wdata", bram_wdata,     32'h13121110);

        applyStimulus(0, 0, 1, 8'hE1);
        applyStimulus(0, 0, 1, 8'hE2);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("midrst_we",    32'(bram_we),    32'd0);
        checkOutput("midrst_addr",  32'(bram_addr),  32'd0);
        checkOutput("midrst_wdata", bram_wdata,      32'd0);
        checkOutput("midrst_busy",  32'(busy),       32'd0);
        checkOutput("midrst_done",  32'(done),       32'd0);
        checkOutput("midrst_ok",    32'(frames_ok),  32'd0);
        checkOutput("midrst_bad",   32'(frames_bad), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("idle_we",   32'(bram_we), 32'd0);
        checkOutput("idle_busy", 32'(busy),    32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 1, 8'h77);
        end
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("idle_we2", 32'(bram_we),   32'd0);
        checkOutput("idle_ok",  32'(frames_ok), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
